// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: per-channel CIC decimation of 1-bit PDM streams,
// snapshot of each decimated frame streamed out channel by channel.
module pdm_cic_decimator #(
  parameter int CHANNELS = 16,
  parameter int DECIM    = 64,
  parameter int ORDER    = 4,
  parameter int OUT_W    = 26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pdm_en,
  input  logic [CHANNELS-1:0]         pdm_bits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [$clog2(CHANNELS)-1:0] out_channel,
  output logic                        out_last,
  output logic                        overrun
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(DECIM);
  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);
  localparam logic [OUT_W-1:0] NEG_ONE = {OUT_W{1'b1}};
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);

  logic [OUT_W-1:0] integ   [CHANNELS][ORDER];
  logic [OUT_W-1:0] dly     [CHANNELS][ORDER];
  logic [OUT_W-1:0] comb_in [CHANNELS][ORDER];
  logic [OUT_W-1:0] comb_out[CHANNELS];
  logic [OUT_W-1:0] frame_q [CHANNELS];
  logic [OUT_W-1:0] acc;

  logic [CNT_W-1:0] cnt;
  logic             dec_tick;
  logic             full;
  logic [CH_W-1:0]  idx;
  logic             hs;
  logic             last_hs;
  logic             load;

  // stage k accumulates the pre-update value of stage k-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < ORDER; k++)
          integ[c][k] <= '0;
    end else if (pdm_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        integ[c][0] <= integ[c][0] + (pdm_bits[c] ? ONE : NEG_ONE);
        for (int k = 1; k < ORDER; k++)
          integ[c][k] <= integ[c][k] + integ[c][k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dec_tick <= 1'b0;
    end else begin
      dec_tick <= pdm_en && (cnt == CNT_W'(DECIM - 1));
      if (pdm_en)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc = integ[c][ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        comb_in[c][k] = acc;
        acc = acc - dly[c][k];
      end
      comb_out[c] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < ORDER; k++)
          dly[c][k] <= '0;
    end else if (dec_tick) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < ORDER; k++)
          dly[c][k] <= comb_in[c][k];
    end
  end

  assign hs      = full && out_ready;
  assign last_hs = hs && (idx == LAST_CH);
  assign load    = dec_tick && (!full || last_hs);

  // a reload in the final-beat cycle keeps full set with no gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++)
        frame_q[c] <= '0;
      full    <= 1'b0;
      idx     <= '0;
      overrun <= 1'b0;
    end else if (load) begin
      for (int c = 0; c < CHANNELS; c++)
        frame_q[c] <= comb_out[c];
      full <= 1'b1;
      idx  <= '0;
    end else begin
      if (dec_tick)
        overrun <= 1'b1;
      if (hs) begin
        idx <= last_hs ? '0 : idx + CH_W'(1);
        if (last_hs)
          full <= 1'b0;
      end
    end
  end

  assign out_valid   = full;
  assign out_data    = frame_q[idx];
  assign out_channel = idx;
  assign out_last    = (idx == LAST_CH);

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: directed stimulus, expected beats queued per
// frame and popped by an independent handshake monitor.
module tb_pdm_cic_decimator;

  localparam int CH = 16;
  localparam logic [25:0] POS_SS = 26'h1000000;
  localparam logic [25:0] NEG_SS = 26'h3000000;
  // frame 0 after reset for a constant input: C(64,4) = 635376
  localparam logic [25:0] POS_F0 = 26'h009B1F0;
  localparam logic [25:0] NEG_F0 = 26'h3F64E10;

  typedef struct {
    logic [25:0] data;
    logic [3:0]  ch;
    logic        last;
    logic        chk;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        pdm_en;
  logic [15:0] pdm_bits;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_data;
  logic [3:0]  out_channel;
  logic        out_last;
  logic        overrun;

  exp_t sb[$];
  exp_t m_e;
  int   n_chk;
  int   n_pass;
  int   pulses;
  int   pat;
  int   skip_frame;

  pdm_cic_decimator dut (
    .clk         (clk),
    .rst         (rst),
    .pdm_en      (pdm_en),
    .pdm_bits    (pdm_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_last    (out_last),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic logic [15:0] gen_bits(int p, int n);
    case (p)
      0: return 16'hFFFF;
      1: return 16'h0000;
      default: return (n % 2 == 0) ? 16'hFFFD : 16'h0001;
    endcase
  endfunction

  task automatic push_frame(int f);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      e.ch   = 4'(c);
      e.last = (c == CH - 1);
      e.chk  = 1'b0;
      e.data = '0;
      case (pat)
        0: begin
          e.data = (f == 0) ? POS_F0 : POS_SS;
          e.chk  = (f == 0) || (f >= 4);
        end
        1: begin
          e.data = (f == 0) ? NEG_F0 : NEG_SS;
          e.chk  = (f == 0) || (f >= 4);
        end
        default: begin
          if (f >= 4) begin
            e.chk  = 1'b1;
            e.data = (c == 0) ? POS_SS : (c == 1) ? NEG_SS : 26'h0;
          end else if (f == 0 && c < 2) begin
            e.chk  = 1'b1;
            e.data = (c == 0) ? POS_F0 : NEG_F0;
          end
        end
      endcase
      sb.push_back(e);
    end
  endtask

  task automatic cyc(logic en, logic rdy);
    @(posedge clk);
    #1;
    pdm_en    = en;
    out_ready = rdy;
    pdm_bits  = gen_bits(pat, pulses);
    if (en) begin
      if (pulses % 64 == 63 && pulses / 64 != skip_frame)
        push_frame(pulses / 64);
      pulses++;
    end
  endtask

  task automatic do_reset();
    #2;
    rst       = 1'b0;
    pdm_en    = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_channel", 32'(out_channel), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_overrun", 32'(overrun), 0);
    sb.delete();
    pulses = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    repeat (4) cyc(1'b0, 1'b1);
    check("drain_empty", 32'(sb.size()), 0);
    check("idle_valid", 32'(out_valid), 0);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      check("sb_avail", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        m_e = sb.pop_front();
        check("beat_channel", 32'(out_channel), 32'(m_e.ch));
        check("beat_last", 32'(out_last), 32'(m_e.last));
        if (m_e.chk)
          check("beat_data", 32'(out_data), 32'(m_e.data));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    pulses     = 0;
    pat        = 0;
    skip_frame = -1;
    rst        = 1'b1;
    pdm_en     = 1'b0;
    out_ready  = 1'b0;
    pdm_bits   = '0;
    do_reset();

    for (int p = 0; p < 3; p++) begin
      pat = p;
      for (int i = 0; i < 6 * 64; i++) cyc(1'b1, 1'b1);
      drain();
      check("no_overrun", 32'(overrun), 0);
      do_reset();
    end

    pat        = 0;
    skip_frame = 1;
    for (int cy = 0; cy < 1100; cy++) begin
      cyc(cy % 4 == 0, !(cy >= 240 && cy < 540));
      if (cy >= 254 && cy < 540) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_channel", 32'(out_channel), 0);
        check("stall_data", 32'(out_data), 32'(POS_F0));
      end
      if (cy == 505) check("ovr_before", 32'(overrun), 0);
      if (cy == 539) check("ovr_set", 32'(overrun), 1);
    end
    drain();
    check("ovr_sticky", 32'(overrun), 1);
    skip_frame = -1;
    do_reset();

    pat = 0;
    for (int cy = 0; cy < 7 * 64; cy++) begin
      cyc(1'b1, (cy % 64 >= 49) || (cy % 64 == 0));
      if (cy >= 65) check("cont_valid", 32'(out_valid), 1);
      if (cy == 129) check("next_ch0", 32'(out_channel), 0);
    end
    check("coincide_no_ovr", 32'(overrun), 0);
    drain();
    do_reset();

    pat = 0;
    for (int cy = 0; cy < 100; cy++) begin
      cyc(1'b1, cy >= 65 && cy < 72);
      if (cy == 90) begin
        check("beat7_valid", 32'(out_valid), 1);
        check("beat7_channel", 32'(out_channel), 7);
        check("beat7_data", 32'(out_data), 32'(POS_F0));
      end
    end
    do_reset();
    for (int i = 0; i < 6 * 64; i++) cyc(1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Multi-channel PDM-to-PCM decimator that sits directly downstream of the DDR-to-SDR demux stage. It takes the per-microphone 1-bit PDM streams that stage produces, runs one CIC decimation filter per channel, and captures each decimated frame into a snapshot buffer. It then streams the frame out channel-by-channel over a valid/ready interface to the PCM processing chain.

## Interface
- CHANNELS, 16, number of mic channels; bit i of `pdm_bits` is channel i (`{sdr_data_1, sdr_data_0}` from the demux)
- DECIM, 64, decimation ratio in PDM samples; power of two, ≥ 2·CHANNELS
- ORDER, 4, CIC order (integrator count = comb count)
- OUT_W, 26, signed output width; must be ≥ ORDER·log2(DECIM)+2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pdm_en  in  1  one-cycle strobe: `pdm_bits` holds a new PDM sample this cycle
- pdm_bits  in  CHANNELS  one PDM bit per channel; 1 → +1, 0 → −1
- out_valid  out  1  `out_data` holds a valid PCM sample
- out_ready  in  1  consumer accepts the sample this cycle
- out_data  out  OUT_W  signed two's-complement PCM sample
- out_channel  out  clog2(CHANNELS)  channel index of `out_data`
- out_last  out  1  high with the channel CHANNELS−1 sample
- overrun  out  1  sticky; a decimated frame was dropped

## Operation
- Integrators: each channel has ORDER cascaded integrators, updated only on `pdm_en`. Stage 1 adds ±1. Stage k adds the stage k−1 value from before the update, so each stage adds 1 cycle of pipeline delay. All arithmetic is OUT_W-bit and wraps modulo 2^OUT_W; the comb differences cancel the wrap exactly.
- Sample counter `cnt` (0..DECIM−1) increments on `pdm_en` and wraps. A `pdm_en` with `cnt==DECIM−1` sets `dec_tick` on the next cycle.
- Combs: on a `dec_tick` cycle, each channel's ORDER-stage comb chain (differential delay 1) is evaluated combinationally from the last-integrator value.
  - The comb delay registers update on that edge.
  - The chain output is offered to the frame buffer.
  - Comb state updates on every `dec_tick`, even when the frame is dropped.
- Frame buffer: CHANNELS × OUT_W registers plus a `full` flag.
  - On `dec_tick`, if `full`=0 or the final beat (channel CHANNELS−1) handshakes in this same cycle: load all channels, set `full`, set read index to 0.
  - Otherwise, discard the new frame, keep the buffered frame intact, and set `overrun`.
- Stream behaviour:
  - `out_valid`=`full`; `out_data`=buffer[idx]; `out_channel`=idx; `out_last`=(idx==CHANNELS−1).
  - A transfer occurs on `out_valid && out_ready`, and idx then increments.
  - The transfer of the last channel clears `full` unless a reload happens in the same cycle.
  - `out_valid` never drops without a handshake. `out_data` and `out_channel` are stable while stalled.
- Settling: frames 0..ORDER−1 after reset are transient. From frame ORDER onward, the output equals the exact CIC response. DC gain is DECIM^ORDER (2^24 at defaults).
- Reset (asynchronous assert at any time, including mid-frame or mid-stall) clears:
  - all integrators, comb delays, `cnt`, `dec_tick`, buffer, idx and `full`;
  - `out_valid`=0, `out_data`=0, `out_channel`=0, `out_last`=0, `overrun`=0.
- Deassertion is synchronous to `clk`; the first `pdm_en` after deassertion is sample 0.

## Timing
- Cycle T: `pdm_en`=1 with `cnt==DECIM−1`. T+1: `dec_tick`, comb evaluated, buffer loaded. T+2: `out_valid`=1 with channel 0.
- Latency from the last PDM sample of a frame to the first output is 2 cycles. With `out_ready` held high, a full frame drains in CHANNELS cycles.
- `pdm_en` may be asserted on consecutive cycles. Ticks are always separated by DECIM `pdm_en` pulses.
- Same-cycle final handshake and `dec_tick` is not an overrun. `out_valid` stays 1 and channel 0 of the new frame appears at the next cycle.
- `pdm_en` in a `dec_tick` cycle is processed normally; the integrators and combs are independent.

## Test plan
- All channels held at 1, `pdm_en` every cycle, `out_ready`=1 → every channel of frames ≥4 reads +16777216 (26'h1000000), `out_last` high on channel 15 only.
- All channels held at 0 → frames ≥4 read −16777216 (26'h3000000) on every channel.
- Channel 0 = 1, channel 1 = 0, others alternate 1/0 per sample → frames ≥4 read +16777216, −16777216, and 0 for the rest, in order with `out_channel` 0..15.
- `pdm_en` every 4th cycle, `out_ready` low for 300 cycles spanning two ticks → `overrun` goes to 1 and stays at 1. The stalled frame's values and channel-0 data are unchanged throughout the stall. After release, 16 beats are followed by the next frame.
- Ready pulsed so the channel-15 handshake coincides with `dec_tick` → `overrun` stays 0, `out_valid` is continuous, and the next beat is channel 0.
- Assert `rst`=0 during beat 7 of a stalled frame → all outputs are 0 asynchronously. After release with all-ones input, the first four frames are transient and frame 4 reads +16777216.
